// File: rtl/alu_seq_core_if.sv
// rtl/alu_seq_core_if.sv - request/result handshake bundle for alu_seq_core
interface alu_seq_core_if #(
    parameter int WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       FunSel;
    logic             WF;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ALUOut;
    logic [3:0]       FlagsOut;

    modport master (
        output InValid, A, B, FunSel, WF, OutReady,
        input  InReady, OutValid, ALUOut, FlagsOut
    );

    modport slave (
        input  InValid, A, B, FunSel, WF, OutReady,
        output InReady, OutValid, ALUOut, FlagsOut
    );
endinterface

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - handshaked 16-op ALU on full or half width; ALU_VAR_SHIFT_EN adds multi-cycle variable shifts
module alu_seq_core #(
    parameter int WIDTH = 32
) (
    input  logic          Clock,
    input  logic          Reset,
    alu_seq_core_if.slave bus
);
    localparam int HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

    localparam logic [3:0] OP_A    = 4'h0;
    localparam logic [3:0] OP_B    = 4'h1;
    localparam logic [3:0] OP_NOTA = 4'h2;
    localparam logic [3:0] OP_NOTB = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_LSL  = 4'hB;
    localparam logic [3:0] OP_LSR  = 4'hC;
    localparam logic [3:0] OP_ASR  = 4'hD;
    localparam logic [3:0] OP_ROR  = 4'hE;
    localparam logic [3:0] OP_ROL  = 4'hF;

    function automatic logic [WIDTH-1:0] width_mask(input logic full);
        return full ? {WIDTH{1'b1}} : HALF_MASK;
    endfunction

    function automatic logic msb_of(input logic full, input logic [WIDTH-1:0] x);
        return full ? x[WIDTH-1] : x[HALF-1];
    endfunction

    // One-bit shift/rotate of an n-bit word; returns {carry_out, word}. Rotates go through c.
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] op, input logic full,
                                                  input logic [WIDTH-1:0] w, input logic c);
        logic [WIDTH-1:0] msk;
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] nw;
        logic             nc;
        logic             msb;
        msk = width_mask(full);
        top = full ? {1'b1, {(WIDTH-1){1'b0}}} : {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}};
        msb = msb_of(full, w);
        nw  = '0;
        nc  = 1'b0;
        case (op)
            OP_LSL:  begin nw = (w << 1) & msk;                              nc = msb;  end
            OP_LSR:  begin nw = w >> 1;                                      nc = w[0]; end
            OP_ASR:  begin nw = (w >> 1) | (msb ? top : '0);                 nc = w[0]; end
            OP_ROR:  begin nw = (w >> 1) | (c ? top : '0);                   nc = w[0]; end
            OP_ROL:  begin nw = ((w << 1) & msk) | {{(WIDTH-1){1'b0}}, c};  nc = msb;  end
            default: begin nw = w;                                           nc = c;    end
        endcase
        return {nc, nw};
    endfunction

    logic [WIDTH-1:0] alu_q;
    logic [3:0]       flags_q;
    logic             valid_q;

    logic             full_i;
    logic [3:0]       op_i;
    logic             cin;
    logic [WIDTH-1:0] mask_i;
    logic [WIDTH-1:0] am;
    logic [WIDTH-1:0] bm;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] ss_res;
    logic             ss_c;
    logic             ss_o;
    logic [3:0]       ss_flags;

    logic             in_ready;
    logic             accept;
    logic             complete;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       flags_d;
    logic             wf_d;

    // Result of any operation that finishes in the accept cycle; carry-in is the live C flag.
    always_comb begin
        full_i = bus.FunSel[4];
        op_i   = bus.FunSel[3:0];
        cin    = flags_q[2];
        mask_i = width_mask(full_i);
        am     = bus.A & mask_i;
        bm     = bus.B & mask_i;
        bx     = (op_i == OP_SUB) ? (~bus.B & mask_i) : bm;
        sum    = {1'b0, am} + {1'b0, bx}
               + {{WIDTH{1'b0}}, (op_i == OP_ADC) ? cin : (op_i == OP_SUB)};
        ss_res = '0;
        ss_c   = 1'b0;
        ss_o   = 1'b0;
        case (op_i)
            OP_A:    ss_res = am;
            OP_B:    ss_res = bm;
            OP_NOTA: ss_res = ~bus.A & mask_i;
            OP_NOTB: ss_res = ~bus.B & mask_i;
            OP_AND:  ss_res = am & bm;
            OP_OR:   ss_res = am | bm;
            OP_XOR:  ss_res = am ^ bm;
            OP_NAND: ss_res = ~(am & bm) & mask_i;
            OP_ADD, OP_ADC, OP_SUB: begin
                ss_res = sum[WIDTH-1:0] & mask_i;
                ss_c   = full_i ? sum[WIDTH] : sum[HALF];
                ss_o   = (msb_of(full_i, am) == msb_of(full_i, bx))
                      && (msb_of(full_i, ss_res) != msb_of(full_i, am));
            end
            default: begin
`ifdef ALU_VAR_SHIFT_EN
                // Only a zero shift amount finishes here: operand and carry pass straight through.
                ss_res = am;
                ss_c   = cin;
`else
                {ss_c, ss_res} = shift_step(op_i, full_i, am, cin);
`endif
            end
        endcase
        ss_flags = {(ss_res == '0), ss_c, msb_of(full_i, ss_res), ss_o};
    end

`ifdef ALU_VAR_SHIFT_EN
    localparam int CW  = $clog2(WIDTH);
    localparam int HCW = $clog2(HALF);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] wrk_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic [3:0]       op_q;
    logic             full_q;
    logic             wf_q;
    logic [CW-1:0]    shift_amt;
    logic             multi_step;
    logic             load_work;
    logic [WIDTH:0]   step;

    assign shift_amt  = full_i ? bus.B[CW-1:0] : CW'(bus.B[HCW-1:0]);
    assign multi_step = (op_i >= OP_LSL) && (shift_amt != '0);
    assign step       = shift_step(op_q, full_q, wrk_q, c_q);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        load_work = 1'b0;
        res_d     = ss_res;
        flags_d   = ss_flags;
        wf_d      = bus.WF;
        case (state_q)
            IDLE: begin
                in_ready = !valid_q || bus.OutReady;
                accept   = bus.InValid && in_ready;
                if (accept) begin
                    if (multi_step) begin
                        load_work = 1'b1;
                        state_d   = SHIFT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(1)) begin
                    complete = 1'b1;
                    res_d    = step[WIDTH-1:0];
                    flags_d  = {(step[WIDTH-1:0] == '0), step[WIDTH],
                                msb_of(full_q, step[WIDTH-1:0]), 1'b0};
                    wf_d     = wf_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrk_q  <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            op_q   <= OP_A;
            full_q <= 1'b0;
            wf_q   <= 1'b0;
        end else if (load_work) begin
            wrk_q  <= am;
            cnt_q  <= shift_amt;
            c_q    <= cin;
            op_q   <= op_i;
            full_q <= full_i;
            wf_q   <= bus.WF;
        end else if (state_q == SHIFT) begin
            wrk_q <= step[WIDTH-1:0];
            cnt_q <= cnt_q - CW'(1);
            c_q   <= step[WIDTH];
        end
    end
`else
    assign in_ready = !valid_q || bus.OutReady;
    assign accept   = bus.InValid && in_ready;
    assign complete = accept;
    assign res_d    = ss_res;
    assign flags_d  = ss_flags;
    assign wf_d     = bus.WF;
`endif

    // A completion always lands on a free or simultaneously drained output slot.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            alu_q   <= '0;
            flags_q <= 4'b0000;
            valid_q <= 1'b0;
        end else if (complete) begin
            alu_q   <= res_d;
            valid_q <= 1'b1;
            if (wf_d) begin
                flags_q <= flags_d;
            end
        end else if (bus.OutReady) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = valid_q;
    assign bus.ALUOut   = alu_q;
    assign bus.FlagsOut = flags_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - randomized and directed checks of alu_seq_core against an arithmetic model
module tb_alu_seq_core;
    localparam int WIDTH = 32;

    logic        clk;
    logic        rst_n;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_flags;
    logic [31:0] exp_res;

    alu_seq_core_if #(.WIDTH(WIDTH)) bus ();
    alu_seq_core #(.WIDTH(WIDTH)) dut (.Clock(clk), .Reset(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] r, output logic [3:0] f,
                                  output int lat);
        int                n;
        int                k;
        int                kk;
        longint unsigned   mask, sbit, x, y, t, v, m1;
        longint            sa, sb, s, tmp, maxp, minn;
        logic              c, o;
        n    = fs[4] ? 32 : 16;
        mask = (64'd1 << n) - 64'd1;
        sbit = 64'd1 << (n - 1);
        x    = {32'd0, a} & mask;
        y    = {32'd0, b} & mask;
        sa   = $signed(x ^ sbit) - $signed(sbit);
        sb   = $signed(y ^ sbit) - $signed(sbit);
        maxp = $signed(sbit) - 64'sd1;
        minn = -$signed(sbit);
        c = 1'b0; o = 1'b0; t = 0; lat = 1;
`ifdef ALU_VAR_SHIFT_EN
        k = int'(y % longint'(n));
`else
        k = 1;
`endif
        case (fs[3:0])
            4'h0: t = x;
            4'h1: t = y;
            4'h2: t = ~x & mask;
            4'h3: t = ~y & mask;
            4'h4: begin t = x + y; c = t[n]; s = sa + sb; o = (s > maxp) || (s < minn); end
            4'h5: begin
                t = x + y + (cin ? 64'd1 : 64'd0); c = t[n];
                s = sa + sb + (cin ? 64'sd1 : 64'sd0); o = (s > maxp) || (s < minn);
            end
            4'h6: begin t = (x - y) & mask; c = (x >= y); s = sa - sb; o = (s > maxp) || (s < minn); end
            4'h7: t = x & y;
            4'h8: t = x | y;
            4'h9: t = x ^ y;
            4'hA: t = ~(x & y);
            default: begin
                if (k == 0) begin
                    t = x; c = cin;
                end else begin
                    lat = (k > 1) ? k : 1;
                    m1  = (64'd1 << (n + 1)) - 64'd1;
                    kk  = k % (n + 1);
                    v   = ((cin ? 64'd1 : 64'd0) << n) | x;
                    case (fs[3:0])
                        4'hB: begin t = x << k; c = x[n-k]; end
                        4'hC: begin t = x >> k; c = x[k-1]; end
                        4'hD: begin tmp = sa >>> (k - 1); c = tmp[0]; t = $unsigned(sa >>> k); end
                        4'hE: begin v = ((v >> kk) | (v << (n + 1 - kk))) & m1; t = v; c = v[n]; end
                        default: begin v = ((v << kk) | (v >> (n + 1 - kk))) & m1; t = v; c = v[n]; end
                    endcase
                end
            end
        endcase
`ifndef ALU_VAR_SHIFT_EN
        lat = 1;
`endif
        t = t & mask;
        r = t[31:0];
        f = {(t == 0), c, t[n-1], o};
    endfunction

    task automatic do_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b, input logic wf);
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        int          seen;
        bit          done;
        model(fs, a, b, exp_flags[2], r, f, lat);
        @(negedge clk);
        bus.FunSel = fs; bus.A = a; bus.B = b; bus.WF = wf;
        bus.InValid = 1'b1; bus.OutReady = 1'b1;
        check("in_ready_idle", 32'(bus.InReady), 32'd1);
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        seen = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            seen++;
            if (lat > 1 && seen == 1) check("in_ready_busy", 32'(bus.InReady), 32'd0);
            if (bus.OutValid) done = 1;
        end
        check("done_in_budget", 32'(done), 32'd1);
        check("latency", 32'(seen), 32'(lat));
        check("alu_out", bus.ALUOut, r);
        if (wf) exp_flags = f;
        check("flags", 32'(bus.FlagsOut), 32'(exp_flags));
        exp_res = r;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_8000;
            default: return $urandom;
        endcase
    endfunction

    task automatic stall_test();
        logic [31:0] rp, rq;
        logic [3:0]  fp, fq;
        int          l;
        @(negedge clk);
        bus.InValid = 1'b0; bus.OutReady = 1'b1;
        @(negedge clk);
        model(5'b10100, 32'h1234_5678, 32'hF111_1111, exp_flags[2], rp, fp, l);
        bus.FunSel = 5'b10100; bus.A = 32'h1234_5678; bus.B = 32'hF111_1111; bus.WF = 1'b1;
        bus.InValid = 1'b1; bus.OutReady = 1'b0;
        @(posedge clk);
        #1;
        exp_flags = fp;
        model(5'b11001, 32'hA5A5_0F0F, 32'h5A5A_0F0F, exp_flags[2], rq, fq, l);
        bus.FunSel = 5'b11001; bus.A = 32'hA5A5_0F0F; bus.B = 32'h5A5A_0F0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.InReady), 32'd0);
            check("stall_valid", 32'(bus.OutValid), 32'd1);
            check("stall_alu", bus.ALUOut, rp);
            check("stall_flags", 32'(bus.FlagsOut), 32'(fp));
        end
        bus.OutReady = 1'b1;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        @(negedge clk);
        check("held_valid", 32'(bus.OutValid), 32'd1);
        check("held_alu", bus.ALUOut, rq);
        check("held_flags", 32'(bus.FlagsOut), 32'(fq));
        exp_flags = fq;
    endtask

    task automatic b2b_test();
        @(negedge clk);
        bus.FunSel = 5'b10100; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1; bus.WF = 1'b1;
        bus.InValid = 1'b1; bus.OutReady = 1'b1;
        @(posedge clk);
        #1;
        bus.FunSel = 5'b10101; bus.A = 32'd2; bus.B = 32'd3;
        @(negedge clk);
        check("b2b_add_res", bus.ALUOut, 32'd0);
        check("b2b_add_flags", 32'(bus.FlagsOut), 32'b1100);
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        @(negedge clk);
        check("b2b_adc_valid", 32'(bus.OutValid), 32'd1);
        check("b2b_adc_res", bus.ALUOut, 32'd6);
        check("b2b_adc_flags", 32'(bus.FlagsOut), 32'b0000);
        exp_flags = 4'b0000;
    endtask

    task automatic reset_test();
        @(negedge clk);
`ifdef ALU_VAR_SHIFT_EN
        bus.FunSel = 5'b11011; bus.A = 32'd1; bus.B = 32'd8; bus.WF = 1'b1;
        bus.InValid = 1'b1; bus.OutReady = 1'b1;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
`else
        bus.FunSel = 5'b10100; bus.A = 32'd5; bus.B = 32'd6; bus.WF = 1'b1;
        bus.InValid = 1'b1; bus.OutReady = 1'b0;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.OutValid), 32'd0);
        check("rst_alu", bus.ALUOut, 32'd0);
        check("rst_flags", 32'(bus.FlagsOut), 32'd0);
        check("rst_in_ready", 32'(bus.InReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.OutReady = 1'b1;
        exp_flags = 4'b0000;
        repeat (10) @(negedge clk);
        check("rst_discarded", 32'(bus.OutValid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.InValid = 1'b0; bus.OutReady = 1'b1;
        bus.A = '0; bus.B = '0; bus.FunSel = '0; bus.WF = 1'b0;
        exp_flags = 4'b0000;
        exp_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_valid", 32'(bus.OutValid), 32'd0);
        check("reset_alu", bus.ALUOut, 32'd0);
        check("reset_flags", 32'(bus.FlagsOut), 32'd0);
        check("reset_in_ready", 32'(bus.InReady), 32'd1);

        do_op(5'b10100, 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("add_ovf_res", bus.ALUOut, 32'd0);
        check("add_ovf_flags", 32'(bus.FlagsOut), 32'b1100);
        do_op(5'b00110, 32'h0000_8000, 32'd1, 1'b1);
        check("hsub_res", bus.ALUOut, 32'h0000_7FFF);
        check("hsub_flags", 32'(bus.FlagsOut), 32'b0101);
        do_op(5'b10111, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1);
        do_op(5'b00110, 32'h0000_8000, 32'd1, 1'b0);
        check("hsub_nowf_flags", 32'(bus.FlagsOut), 32'b1000);

        b2b_test();
        stall_test();

`ifdef ALU_VAR_SHIFT_EN
        do_op(5'b11011, 32'h8000_0001, 32'd4, 1'b1);
        check("vlsl_res", bus.ALUOut, 32'h0000_0010);
        check("vlsl_c", 32'(bus.FlagsOut[2]), 32'd0);
        do_op(5'b10100, 32'hFFFF_FFFF, 32'd1, 1'b1);
        do_op(5'b11011, 32'h8000_0001, 32'd0, 1'b1);
        check("vlsl0_res", bus.ALUOut, 32'h8000_0001);
        check("vlsl0_c", 32'(bus.FlagsOut[2]), 32'd1);
`else
        do_op(5'b11011, 32'h8000_0001, 32'd4, 1'b1);
        check("lsl1_res", bus.ALUOut, 32'h0000_0002);
        check("lsl1_c", 32'(bus.FlagsOut[2]), 32'd1);
`endif

        for (int i = 0; i < 250; i++) begin
            do_op(5'($urandom), pick(), pick(), 1'($urandom));
        end

        do_op(5'b10100, 32'd1, 32'd1, 1'b1);
        reset_test();
        do_op(5'b11110, 32'h0000_0003, 32'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor to the team's fixed 16/32-bit ALU. Performs the same 16-operation set on either the full operand width or its lower half. Results and flags are registered behind a valid/ready interface, so the datapath controller can stall it or be stalled by it. Sits between the register-file read ports and the write-back mux; FlagsOut feeds the branch unit.

## Interface
- WIDTH, 32: full operand width; even, ≥ 8. HALF = WIDTH/2.
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- InValid  in  1  operation request
- InReady  out  1  block can accept; combinational = (state==IDLE) && (!OutValid || OutReady)
- A  in  WIDTH  operand 1
- B  in  WIDTH  operand 2 (shift amount when ALU_VAR_SHIFT_EN)
- FunSel  in  5  [4]=1 full width, 0 half width; [3:0] opcode
- WF  in  1  write flags for this operation (sampled at accept)
- OutValid  out  1  ALUOut/FlagsOut hold a completed result
- OutReady  in  1  consumer takes result
- ALUOut  out  WIDTH  result; half mode zero-extends bits [WIDTH-1:HALF]
- FlagsOut  out  4  {Z,C,N,O} = bits 3..0

## Operation
- Accept: InValid && InReady at a rising edge. A, B, FunSel, WF and the carry-in (current FlagsOut[2]) are captured then.
- Effective width n = FunSel[4] ? WIDTH : HALF. Only operand bits [n-1:0] are used.
- Opcodes: 0 A; 1 B; 2 ~A; 3 ~B; 4 ADD A+B; 5 ADC A+B+Cin; 6 SUB A+~B+1; 7 AND; 8 OR; 9 XOR; A NAND; B LSL; C LSR; D ASR; E ROR through carry; F ROL through carry.
- C: the n-bit carry-out for ADD/ADC/SUB (SUB C=1 means no borrow). For shifts and rotates, C is the last bit shifted out. C=0 for all other ops.
- O: signed overflow for ADD/ADC (same-sign operands, different-sign result) and SUB (different-sign operands, result sign ≠ A sign). O=0 otherwise.
- Z: the n-bit result is zero. N: result bit n-1. All four flags are computed from the new result, never from the previous one.
- WF=1: FlagsOut is written when the result is written. WF=0: FlagsOut is unchanged.
- FSM has two states:
  - IDLE: on accept of a single-step op, register the result, set OutValid, stay in IDLE. On accept of a multi-step shift, go to SHIFT.
  - SHIFT: shift the working register by one bit per cycle and decrement the count. When the count reaches 0, register the result and flags, set OutValid, and return to IDLE.
- While OutValid && !OutReady: ALUOut and FlagsOut are held stable and nothing is accepted. OutValid && OutReady with no new completion clears OutValid on that edge.

## Timing
- Reset (asynchronous assert, synchronous release): ALUOut=0, FlagsOut=4'b0000, OutValid=0, FSM=IDLE, so InReady=1.
- Reset asserted mid-shift or with a result pending: the operation is discarded with no output.
- Single-step ops: accepted at edge E0; OutValid=1 and result visible after E0 (latency 1). Throughput is 1 per cycle while OutReady=1.
- Completion and OutReady on the same edge: the new result replaces the old one and OutValid stays 1.
- Back-to-back ADC/ROR/ROL use the flag written by the previous completion as carry-in.
- Multi-step shift by k ≥ 1: accept E0, shifts at E1..Ek, OutValid after Ek. InReady=0 from E0 to Ek.
- Shift amount 0: completes like a single-step op; result = A[n-1:0]; C = Cin (carry-in passed through).

## Configuration
- ALU_VAR_SHIFT_EN defined: opcodes B–F shift by k = B[log2(n)-1:0] using the SHIFT state. ASR refills with the sign bit; rotates pass through C on every step.
- ALU_VAR_SHIFT_EN undefined: opcodes B–F shift by exactly 1 in one cycle and B is ignored. The SHIFT state and counter are not built, and InReady reduces to !OutValid || OutReady.

## Test plan
- Reset low while in SHIFT (A=1, LSL, B=8) at the 3rd shift cycle -> OutValid=0, ALUOut=0, FlagsOut=0, InReady=1 immediately after reset.
- FunSel=5'b10100, A=0xFFFFFFFF, B=1, WF=1 -> ALUOut=0, FlagsOut=4'b1100, one cycle after accept.
- FunSel=5'b00110, A=0x00008000, B=1, WF=1 -> ALUOut=0x00007FFF, Z=0, C=1, N=0, O=1. Repeat with WF=0 -> FlagsOut unchanged.
- ADD 0xFFFFFFFF+1 then ADC with A=2, B=3 on the next cycle -> second result 0x00000006 (carry-in 1).
- Hold OutReady=0 for 3 cycles after a result with InValid=1 -> InReady=0, ALUOut and FlagsOut stable, the held op is accepted on the edge OutReady=1 and its result appears one cycle later.
- ALU_VAR_SHIFT_EN defined: FunSel=5'b11011, A=0x80000001, B=4 -> ALUOut=0x00000010, C=0, OutValid 4 cycles after the accept edge. With B=0 -> ALUOut=0x80000001, C=previous C.
